// File: rtl/key_schedule.sv
// RC4 key-scheduling stage: fills the shared 256x8 S memory with the
// identity permutation, then permutes it with the latched secret key.
// The S-memory port is driven only while busy; done holds until acknowledged.
// Optional feature macro: KSA_CYCLE_COUNT_EN adds a 16-bit cycle_count output
// that counts busy cycles of the most recent schedule.
module key_schedule #(
  parameter int KEY_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    done_ack,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  output logic [7:0]              s_mem_addr,
  output logic [7:0]              s_mem_data_write,
  output logic                    s_mem_wren,
  input  logic [7:0]              s_mem_data_read,
  output logic                    busy,
  output logic                    done
`ifdef KSA_CYCLE_COUNT_EN
  ,
  output logic [15:0]             cycle_count
`endif
);

  localparam int KIW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I_ADDR,
    RD_I_WAIT,
    RD_I,
    COMP_J,
    RD_J_ADDR,
    RD_J_WAIT,
    RD_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [7:0]              i;
  logic [7:0]              j;
  logic [7:0]              s_i;
  logic [7:0]              s_j;
  logic [8*KEY_LENGTH-1:0] key_q;
  logic [KIW-1:0]          key_idx;
  logic [7:0]              key_byte;

  // key_idx tracks i mod KEY_LENGTH; byte 0 of the key sits in the MSBs
  assign key_byte = key_q[(8*KEY_LENGTH-1) - 8*int'(key_idx) -: 8];

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Index, key and swap-operand registers advanced by the current state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i       <= '0;
      j       <= '0;
      s_i     <= '0;
      s_j     <= '0;
      key_q   <= '0;
      key_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q   <= secret_key;
            i       <= '0;
            j       <= '0;
            key_idx <= '0;
          end
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hff) begin
            key_idx <= '0;
          end
        end
        RD_I: begin
          s_i <= s_mem_data_read;
        end
        COMP_J: begin
          j <= j + s_i + key_byte;
        end
        RD_J: begin
          s_j <= s_mem_data_read;
        end
        WR_J: begin
          if (i != 8'hff) begin
            i       <= i + 8'd1;
            key_idx <= (key_idx == KIW'(KEY_LENGTH - 1)) ? '0 : key_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and memory-port / status outputs
  always_comb begin
    state_next       = state;
    s_mem_addr       = 8'd0;
    s_mem_data_write = 8'd0;
    s_mem_wren       = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = INIT;
        end
      end
      INIT: begin
        s_mem_addr       = i;
        s_mem_data_write = i;
        s_mem_wren       = 1'b1;
        if (i == 8'hff) begin
          state_next = RD_I_ADDR;
        end
      end
      RD_I_ADDR: begin
        s_mem_addr = i;
        state_next = RD_I_WAIT;
      end
      RD_I_WAIT: begin
        s_mem_addr = i;
        state_next = RD_I;
      end
      RD_I: begin
        state_next = COMP_J;
      end
      COMP_J: begin
        state_next = RD_J_ADDR;
      end
      RD_J_ADDR: begin
        s_mem_addr = j;
        state_next = RD_J_WAIT;
      end
      RD_J_WAIT: begin
        s_mem_addr = j;
        state_next = RD_J;
      end
      RD_J: begin
        state_next = WR_I;
      end
      WR_I: begin
        s_mem_addr       = i;
        s_mem_data_write = s_j;
        s_mem_wren       = 1'b1;
        state_next       = WR_J;
      end
      WR_J: begin
        s_mem_addr       = j;
        s_mem_data_write = s_i;
        s_mem_wren       = 1'b1;
        state_next       = (i == 8'hff) ? DONE : RD_I_ADDR;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (done_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

`ifdef KSA_CYCLE_COUNT_EN
  // Busy-cycle counter: cleared on an accepted start, frozen outside busy states
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_count <= 16'd0;
    end else if (state == IDLE && start) begin
      cycle_count <= 16'd0;
    end else if (busy) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

endmodule
